// File: rtl/pipeline_seq_pkg.sv
// pipeline_seq_pkg: shared definitions for the pipeline sequencer.
//   seq_state_e : FSM state encoding (IDLE=0, STEP=1, WAIT=2, DONE=3)
//   clog2()     : ceiling log2, used for derived index and gap-counter widths
package pipeline_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StStep = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } seq_state_e;

  // Smallest r with 2**r >= n; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_step_timer.sv
// step_timer: loadable down-counter with a zero flag. Saturates at zero, never wraps.
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous active-high reset (count -> 0)
//   load_i     in   load load_val_i (has priority over dec_i)
//   load_val_i in   value to load
//   dec_i      in   decrement by one when nonzero
//   count_o    out  current count
//   zero_o     out  count is zero
module step_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: fires one load-enable pulse per pipeline stage, in order, on each
// sample start, with STEP_CYCLES clocks between consecutive enables. Reports busy/done
// and a sticky overrun flag for lost starts.
// Optional build macro SEQ_START_QUEUE_EN: adds a one-deep pending start that is
// replayed when the current pass finishes instead of being dropped.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   request one pass through all stages
//   abort        in   cancel current pass (highest priority)
//   clr_overrun  in   clear sticky overrun
//   en_stage     out  one-hot stage load enables (registered)
//   stage_idx    out  stage being sequenced, 0 when idle (registered)
//   busy         out  pass in progress (registered)
//   done         out  one-cycle pass-complete pulse (registered)
//   overrun      out  sticky lost-start flag (registered)
module pipeline_sequencer
  import pipeline_seq_pkg::*;
#(
  parameter int unsigned STAGES      = 4,
  parameter int unsigned STEP_CYCLES = 1,
  localparam int unsigned SW         = clog2(STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              clr_overrun,
  output logic [STAGES-1:0] en_stage,
  output logic [SW-1:0]     stage_idx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned SW_GAP = clog2(STEP_CYCLES + 1);
  localparam logic [SW-1:0] LastK = SW'(STAGES - 1);

  seq_state_e        state_q, state_d;
  logic [SW-1:0]     k_q, k_d;
  logic [STAGES-1:0] en_stage_q, en_stage_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic              gap_load, gap_dec, gap_zero, gap_done;
  logic [SW_GAP-1:0] gap_cnt;
  logic              go, busy_now, start_lost;

`ifdef SEQ_START_QUEUE_EN
  logic pending_q, pending_d;
`endif

  step_timer #(
    .Width (SW_GAP)
  ) u_gap_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (gap_load),
    .load_val_i (SW_GAP'(STEP_CYCLES - 1)),
    .dec_i      (gap_dec),
    .count_o    (gap_cnt),
    .zero_o     (gap_zero)
  );

  // The timer holds the number of WAIT cycles still to run, including the current one.
  assign gap_done = gap_zero || (gap_cnt == SW_GAP'(1));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    start_lost = 1'b0;
    busy_now   = (state_q == StStep) || (state_q == StWait);
`ifdef SEQ_START_QUEUE_EN
    pending_d  = pending_q;
    go         = start || pending_q;
`else
    go         = start;
`endif

    case (state_q)
      StIdle, StDone: begin
        if (go) begin
          state_d = StStep;
          k_d     = '0;
        end else begin
          state_d = StIdle;
        end
`ifdef SEQ_START_QUEUE_EN
        // A queued start is consumed here; a new start in the same cycle merges with it.
        pending_d = 1'b0;
`endif
      end
      StStep: begin
        gap_load = 1'b1;
        if (k_q == LastK) begin
          state_d = StDone;
          k_d     = '0;
        end else if (STEP_CYCLES > 1) begin
          state_d = StWait;
        end else begin
          k_d = k_q + SW'(1);
        end
      end
      StWait: begin
        gap_dec = 1'b1;
        if (gap_done) begin
          state_d = StStep;
          k_d     = k_q + SW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        k_d     = '0;
      end
    endcase

    if (busy_now && start) begin
`ifdef SEQ_START_QUEUE_EN
      if (pending_q) start_lost = 1'b1;
      else           pending_d  = 1'b1;
`else
      start_lost = 1'b1;
`endif
    end

    if (abort) begin
      state_d    = StIdle;
      k_d        = '0;
      start_lost = 1'b0;
`ifdef SEQ_START_QUEUE_EN
      pending_d  = 1'b0;
`endif
    end

    // Setting beats clearing when both happen in one cycle.
    if (start_lost)       overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;

    // Outputs are decoded from the next state so they are registered with it.
    en_stage_d = (state_d == StStep) ? (STAGES'(1) << k_d) : '0;
    busy_d     = (state_d == StStep) || (state_d == StWait);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      en_stage_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SEQ_START_QUEUE_EN
      pending_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      en_stage_q <= en_stage_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
`ifdef SEQ_START_QUEUE_EN
      pending_q  <= pending_d;
`endif
    end
  end

  assign en_stage  = en_stage_q;
  assign stage_idx = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: two instances (STEP_CYCLES 1 and 3) share stimulus.
// Expected outputs come from a schedule model: each pass is a start edge e0, and the
// outputs at edge n follow from p = n - e0 by arithmetic on STAGES and STEP_CYCLES.
module tb_pipeline_sequencer;

  localparam int unsigned STAGES = 4;
  localparam int NI = 2;

  typedef struct packed {
    logic [3:0] en;
    logic [1:0] idx;
    logic       busy;
    logic       done;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic clr_overrun = 1'b0;

  logic [3:0] en_s   [NI];
  logic [1:0] idx_s  [NI];
  logic       busy_s [NI];
  logic       done_s [NI];
  logic       ovr_s  [NI];

  pipeline_sequencer #(.STAGES(STAGES), .STEP_CYCLES(1)) u_s1 (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .clr_overrun (clr_overrun), .en_stage (en_s[0]), .stage_idx (idx_s[0]),
    .busy (busy_s[0]), .done (done_s[0]), .overrun (ovr_s[0])
  );

  pipeline_sequencer #(.STAGES(STAGES), .STEP_CYCLES(3)) u_s3 (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .clr_overrun (clr_overrun), .en_stage (en_s[1]), .stage_idx (idx_s[1]),
    .busy (busy_s[1]), .done (done_s[1]), .overrun (ovr_s[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  bit running = 1'b0;
  exp_t sb0[$];
  exp_t sb1[$];

  // Model state per instance.
  int e0     [NI];
  bit pend   [NI];
  bit ovr_m  [NI];

  function automatic int step_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic exp_t actual(int i);
    return {en_s[i], idx_s[i], busy_s[i], done_s[i], ovr_s[i]};
  endfunction

  // Expected outputs right after edge n.
  function automatic exp_t model_out(int i, int n);
    exp_t x;
    int p, s, last;
    x = '0;
    s = step_of(i);
    last = (int'(STAGES) - 1) * s;
    x.ovr = ovr_m[i];
    if (e0[i] >= 0) begin
      p = n - e0[i];
      if (p >= 0 && p <= last) begin
        x.busy = 1'b1;
        x.idx  = 2'(p / s);
        if (p % s == 0) x.en = 4'(1) << (p / s);
      end else if (p == last + 1) begin
        x.done = 1'b1;
      end
    end
    return x;
  endfunction

  // Apply inputs sampled at edge n; the pass phase is judged from outputs after edge n-1.
  task automatic model_step(int i, int n, logic s, logic a, logic c);
    int p, last;
    bit busy_ph, lost;
    lost = 1'b0;
    last = (int'(STAGES) - 1) * step_of(i);
    p = (n - 1) - e0[i];
    busy_ph = (e0[i] >= 0) && (p >= 0) && (p <= last);
    if (a) begin
      e0[i] = -1;
      pend[i] = 1'b0;
    end else if (busy_ph) begin
      if (s) begin
`ifdef SEQ_START_QUEUE_EN
        if (pend[i]) lost = 1'b1;
        else         pend[i] = 1'b1;
`else
        lost = 1'b1;
`endif
      end
    end else if (s || pend[i]) begin
      e0[i] = n;
      pend[i] = 1'b0;
    end
    if (lost)   ovr_m[i] = 1'b1;
    else if (c) ovr_m[i] = 1'b0;
  endtask

  task automatic push_exp(int i, exp_t x);
    if (i == 0) sb0.push_back(x);
    else        sb1.push_back(x);
  endtask

  task automatic check(string name, int i, exp_t got, exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s inst=S%0d t=%0t got en=%b idx=%0d busy=%b done=%b ovr=%b want en=%b idx=%0d busy=%b done=%b ovr=%b",
               name, step_of(i), $time, got.en, got.idx, got.busy, got.done, got.ovr,
               want.en, want.idx, want.busy, want.done, want.ovr);
    end
  endtask

  // One clock of stimulus; r=1 holds reset across the coming edge.
  task automatic cycle(logic s, logic a, logic c, logic r);
    @(negedge clk);
    start = s;
    abort = a;
    clr_overrun = c;
    if (r) begin
      if (!reset) begin
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) check("async_reset", i, actual(i), '0);
      end
      for (int i = 0; i < NI; i++) begin
        e0[i] = -1;
        pend[i] = 1'b0;
        ovr_m[i] = 1'b0;
        push_exp(i, '0);
      end
    end else begin
      reset = 1'b0;
      for (int i = 0; i < NI; i++) begin
        model_step(i, edge_n, s, a, c);
        push_exp(i, model_out(i, edge_n));
      end
    end
    running = 1'b1;
    edge_n++;
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every instance after each edge against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (sb0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_empty inst=S1 t=%0t got none want entry", $time);
        end else begin
          check("cycle", 0, actual(0), sb0.pop_front());
        end
        if (sb1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_empty inst=S3 t=%0t got none want entry", $time);
        end else begin
          check("cycle", 1, actual(1), sb1.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      e0[i] = -1;
      pend[i] = 1'b0;
      ovr_m[i] = 1'b0;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Single pass.
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(14);
    // Start while busy.
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(26);
    // Abort mid-pass, then restart.
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0); idle(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(14);
    // Back-to-back start landing on DONE of the 1-cycle instance.
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(4);
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(26);
    // Lost start coinciding with clr_overrun: overrun must stay set.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0); idle(28);
    // Abort together with start: start ignored.
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0); idle(4);
    // Reset during the gap of the 3-cycle instance, then a full pass.
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0); idle(14);
    // Clear overrun on its own.
    cycle(1'b0, 1'b0, 1'b1, 1'b0); idle(2);

    // Randomized traffic.
    for (int j = 0; j < 3000; j++) begin
      cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 39) == 0),
            logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 299) == 0));
    end
    idle(2);

    @(posedge clk);
    #2;
    n_cmp++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got %0d/%0d entries left want 0/0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
